// File: rtl/out_ser_pkg.sv
// Shared types and helpers for the output serializer: FSM states, parity
// and the derived-size functions used to size counters and indices.
package out_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_BYTE_W = 64;

  function automatic int calc_total(input int word_w, input int num_words, input int byte_w);
    return num_words * (word_w / byte_w);
  endfunction

  // Never returns zero so single-entry configurations still get a 1-bit index.
  function automatic int calc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic calc_parity(input logic [MAX_BYTE_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/output_serializer_edge_sync.sv
// Multi-stage synchroniser for the asynchronous listener handshake, followed
// by a rising-edge detector that emits a single-cycle pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Both the chain and the previous-value flop clear, so a level held high
  // through reset only registers once it has propagated through the chain.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/output_serializer.sv
// Snapshots a state-vector on start and presents it byte by byte, MSB-first
// within each word, advancing on every synchronised listener_flag rise.
module output_serializer
  import out_ser_pkg::*;
#(
  parameter int                WORD_W      = 16,
  parameter int                NUM_WORDS   = 48,
  parameter int                BYTE_W      = 8,
  parameter int                PARITY_ODD  = 0,
  parameter logic [BYTE_W-1:0] HEADER      = 8'h8B,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [WORD_W-1:0] psi_f [NUM_WORDS],
  input  logic              start,
  input  logic              listener_flag,
  output logic [BYTE_W-1:0] out,
  output logic              parity,
  output logic              busy,
  output logic              done,
  output logic [calc_width(calc_total(WORD_W, NUM_WORDS, BYTE_W))-1:0] byte_idx
);

  localparam int   TOTAL  = calc_total(WORD_W, NUM_WORDS, BYTE_W);
  localparam int   IDX_W  = calc_width(TOTAL);
  localparam int   CNT_W  = calc_width(TOTAL + 1);
  localparam int   BUF_W  = NUM_WORDS * WORD_W;
  localparam int   BASE_W = calc_width(BUF_W);
  localparam logic ODD    = (PARITY_ODD != 0);

  if ((WORD_W % BYTE_W) != 0) begin : g_badWordWidth
    $error("output_serializer: WORD_W (%0d) must be a multiple of BYTE_W (%0d)", WORD_W, BYTE_W);
  end
  if (SYNC_STAGES < 2) begin : g_badSyncStages
    $error("output_serializer: SYNC_STAGES (%0d) must be at least 2", SYNC_STAGES);
  end
  if (BYTE_W > MAX_BYTE_W) begin : g_badByteWidth
    $error("output_serializer: BYTE_W (%0d) exceeds parity helper width", BYTE_W);
  end

  state_t              r_state;
  state_t              w_nextState;
  logic                w_snap;
  logic                w_advance;
  logic                w_rise;
  logic [CNT_W-1:0]    r_cnt;
  logic [BUF_W-1:0]    r_buf;
  logic [BASE_W-1:0]   w_base;
  logic [BYTE_W-1:0]   w_selByte;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edgeSync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (listener_flag),
    .o_rise  (w_rise)
  );

  // Byte k lives at slot TOTAL-1-k of the buffer because word 0 is packed at the top.
  always_comb begin
    w_base    = BASE_W'((TOTAL - 1 - int'(r_cnt)) * BYTE_W);
    w_selByte = r_buf[w_base +: BYTE_W];
  end

  // A start in IDLE or DONE always wins over a coincident edge.
  always_comb begin
    w_nextState = r_state;
    w_snap      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_snap      = 1'b1;
          w_nextState = SEND;
        end
      end
      SEND: begin
        if (w_rise) begin
          w_advance = 1'b1;
          if (r_cnt == CNT_W'(TOTAL - 1)) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          w_snap      = 1'b1;
          w_nextState = SEND;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      out      <= HEADER;
      parity   <= calc_parity(MAX_BYTE_W'(HEADER), ODD);
      byte_idx <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_snap) begin
        out      <= HEADER;
        parity   <= calc_parity(MAX_BYTE_W'(HEADER), ODD);
        byte_idx <= '0;
        r_cnt    <= '0;
      end else if (w_advance) begin
        out      <= w_selByte;
        parity   <= calc_parity(MAX_BYTE_W'(w_selByte), ODD);
        byte_idx <= r_cnt[IDX_W-1:0];
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  // The buffer needs no reset: it is only read after a snapshot has filled it.
  always_ff @(posedge i_clock) begin
    if (w_snap) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_buf[(NUM_WORDS-1-i)*WORD_W +: WORD_W] <= psi_f[i];
      end
    end
  end

  assign busy = (r_state == SEND);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench: a 4-word even-parity serializer and a default-depth
// odd-parity serializer, checked against hand-computed byte streams.
module tb_output_serializer;

  logic        clk;
  logic        iReset;

  logic [15:0] psiA [4];
  logic        startA, flagA;
  logic [7:0]  outA;
  logic        parA, busyA, doneA;
  logic [2:0]  idxA;

  logic [15:0] psiB [48];
  logic        startB, flagB;
  logic [7:0]  outB;
  logic        parB, busyB, doneB;
  logic [6:0]  idxB;

  int nChecks;
  int nFails;

  output_serializer #(
    .WORD_W(16), .NUM_WORDS(4), .BYTE_W(8), .PARITY_ODD(0), .HEADER(8'h8B), .SYNC_STAGES(2)
  ) dutA (
    .i_clock(clk), .i_reset(iReset), .psi_f(psiA), .start(startA), .listener_flag(flagA),
    .out(outA), .parity(parA), .busy(busyA), .done(doneA), .byte_idx(idxA)
  );

  output_serializer #(
    .WORD_W(16), .NUM_WORDS(48), .BYTE_W(8), .PARITY_ODD(1), .HEADER(8'h8B), .SYNC_STAGES(2)
  ) dutB (
    .i_clock(clk), .i_reset(iReset), .psi_f(psiB), .start(startB), .listener_flag(flagB),
    .out(outB), .parity(parB), .busy(busyB), .done(doneB), .byte_idx(idxB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic riseA();
    flagA = 1'b1;
    tick(3);
    flagA = 1'b0;
    tick(3);
  endtask

  task automatic riseB();
    flagB = 1'b1;
    tick(3);
    flagB = 1'b0;
    tick(3);
  endtask

  task automatic pulseStartA();
    startA = 1'b1;
    tick(1);
    startA = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    tick(3);
    iReset = 1'b0;
    tick(1);
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL reset_out: got %h want 8b", outA); end
    nChecks++; if (parA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_parity: got %b want 0", parA); end
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
    nChecks++; if (doneA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b want 0", doneA); end
    nChecks++; if (idxA !== 3'd0) begin nFails++; $display("[TB] FAIL reset_idx: got %0d want 0", idxA); end
    nChecks++; if (parB !== 1'b1) begin nFails++; $display("[TB] FAIL reset_odd_parity: got %b want 1", parB); end
  endtask

  task automatic test_full_transfer();
    logic [7:0] expByte [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h80, 8'h01};
    logic       expPar  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] prevOut;
    psiA[0] = 16'h1234; psiA[1] = 16'hABCD; psiA[2] = 16'h00FF; psiA[3] = 16'h8001;
    pulseStartA();
    nChecks++; if (busyA !== 1'b1) begin nFails++; $display("[TB] FAIL start_busy: got %b want 1", busyA); end
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL start_header: got %h want 8b", outA); end
    prevOut = 8'h8B;
    for (int k = 0; k < 8; k++) begin
      flagA = 1'b1;
      tick(2);
      nChecks++; if (outA !== prevOut) begin nFails++; $display("[TB] FAIL early_update[%0d]: got %h want %h", k, outA, prevOut); end
      nChecks++; if (doneA !== 1'b0) begin nFails++; $display("[TB] FAIL early_done[%0d]: got %b want 0", k, doneA); end
      tick(1);
      nChecks++; if (outA !== expByte[k]) begin nFails++; $display("[TB] FAIL byte[%0d]: got %h want %h", k, outA, expByte[k]); end
      nChecks++; if (parA !== expPar[k]) begin nFails++; $display("[TB] FAIL parity[%0d]: got %b want %b", k, parA, expPar[k]); end
      nChecks++; if (idxA !== 3'(k)) begin nFails++; $display("[TB] FAIL idx[%0d]: got %0d want %0d", k, idxA, k); end
      nChecks++; if (doneA !== (k == 7)) begin nFails++; $display("[TB] FAIL done[%0d]: got %b want %b", k, doneA, (k == 7)); end
      prevOut = expByte[k];
      flagA = 1'b0;
      tick(3);
    end
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL done_busy: got %b want 0", busyA); end
  endtask

  task automatic test_overrun_restart();
    riseA();
    riseA();
    nChecks++; if (outA !== 8'h01) begin nFails++; $display("[TB] FAIL overrun_out: got %h want 01", outA); end
    nChecks++; if (idxA !== 3'd7) begin nFails++; $display("[TB] FAIL overrun_idx: got %0d want 7", idxA); end
    nChecks++; if (doneA !== 1'b1) begin nFails++; $display("[TB] FAIL overrun_done: got %b want 1", doneA); end
    psiA[0] = 16'hC3A5; psiA[1] = 16'h5A0F; psiA[2] = 16'h7E81; psiA[3] = 16'h0102;
    pulseStartA();
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL restart_header: got %h want 8b", outA); end
    nChecks++; if (busyA !== 1'b1) begin nFails++; $display("[TB] FAIL restart_busy: got %b want 1", busyA); end
    nChecks++; if (doneA !== 1'b0) begin nFails++; $display("[TB] FAIL restart_done: got %b want 0", doneA); end
    riseA();
    nChecks++; if (outA !== 8'hC3) begin nFails++; $display("[TB] FAIL restart_byte0: got %h want c3", outA); end
    nChecks++; if (parA !== 1'b0) begin nFails++; $display("[TB] FAIL restart_parity0: got %b want 0", parA); end
    nChecks++; if (idxA !== 3'd0) begin nFails++; $display("[TB] FAIL restart_idx0: got %0d want 0", idxA); end
  endtask

  task automatic test_snapshot();
    logic [7:0] expByte [7] = '{8'hA5, 8'h5A, 8'h0F, 8'h7E, 8'h81, 8'h01, 8'h02};
    logic       expPar  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    psiA[0] = 16'hDEAD; psiA[1] = 16'hBEEF; psiA[2] = 16'hCAFE; psiA[3] = 16'hF00D;
    for (int k = 0; k < 7; k++) begin
      riseA();
      nChecks++; if (outA !== expByte[k]) begin nFails++; $display("[TB] FAIL snap_byte[%0d]: got %h want %h", k + 1, outA, expByte[k]); end
      nChecks++; if (parA !== expPar[k]) begin nFails++; $display("[TB] FAIL snap_parity[%0d]: got %b want %b", k + 1, parA, expPar[k]); end
    end
    nChecks++; if (doneA !== 1'b1) begin nFails++; $display("[TB] FAIL snap_done: got %b want 1", doneA); end
  endtask

  task automatic test_priority();
    flagA = 1'b1;
    tick(2);
    startA = 1'b1;
    tick(1);
    startA = 1'b0;
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL prio_out: got %h want 8b", outA); end
    nChecks++; if (idxA !== 3'd0) begin nFails++; $display("[TB] FAIL prio_idx: got %0d want 0", idxA); end
    nChecks++; if (busyA !== 1'b1) begin nFails++; $display("[TB] FAIL prio_busy: got %b want 1", busyA); end
    flagA = 1'b0;
    tick(3);
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL prio_no_spurious: got %h want 8b", outA); end
    riseA();
    nChecks++; if (outA !== 8'hDE) begin nFails++; $display("[TB] FAIL prio_first_byte: got %h want de", outA); end
    for (int k = 0; k < 7; k++) riseA();
    nChecks++; if (outA !== 8'h0D) begin nFails++; $display("[TB] FAIL prio_last_byte: got %h want 0d", outA); end
    nChecks++; if (doneA !== 1'b1) begin nFails++; $display("[TB] FAIL prio_done: got %b want 1", doneA); end
  endtask

  task automatic test_reset_mid_op();
    psiA[0] = 16'h1234; psiA[1] = 16'hABCD; psiA[2] = 16'h00FF; psiA[3] = 16'h8001;
    pulseStartA();
    for (int k = 0; k < 6; k++) riseA();
    nChecks++; if (outA !== 8'hFF) begin nFails++; $display("[TB] FAIL mid_byte5: got %h want ff", outA); end
    iReset = 1'b1;
    tick(2);
    iReset = 1'b0;
    tick(1);
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL mid_reset_out: got %h want 8b", outA); end
    nChecks++; if (parA !== 1'b0) begin nFails++; $display("[TB] FAIL mid_reset_parity: got %b want 0", parA); end
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL mid_reset_busy: got %b want 0", busyA); end
    nChecks++; if (idxA !== 3'd0) begin nFails++; $display("[TB] FAIL mid_reset_idx: got %0d want 0", idxA); end
    riseA();
    nChecks++; if (outA !== 8'h8B) begin nFails++; $display("[TB] FAIL idle_ignores_edge: got %h want 8b", outA); end
    pulseStartA();
    riseA();
    nChecks++; if (outA !== 8'h12) begin nFails++; $display("[TB] FAIL mid_restart_byte0: got %h want 12", outA); end
    nChecks++; if (idxA !== 3'd0) begin nFails++; $display("[TB] FAIL mid_restart_idx: got %0d want 0", idxA); end
  endtask

  task automatic test_odd_parity_depth();
    logic [7:0] expByte;
    logic       expPar;
    for (int i = 0; i < 48; i++) psiB[i] = 16'(i);
    startB = 1'b1;
    tick(1);
    startB = 1'b0;
    nChecks++; if (busyB !== 1'b1) begin nFails++; $display("[TB] FAIL odd_busy: got %b want 1", busyB); end
    for (int k = 0; k < 96; k++) begin
      riseB();
      expByte = (k % 2 == 0) ? 8'h00 : 8'(k / 2);
      expPar  = ~(^expByte);
      nChecks++; if (outB !== expByte) begin nFails++; $display("[TB] FAIL odd_byte[%0d]: got %h want %h", k, outB, expByte); end
      nChecks++; if (parB !== expPar) begin nFails++; $display("[TB] FAIL odd_parity[%0d]: got %b want %b", k, parB, expPar); end
      nChecks++; if (idxB !== 7'(k)) begin nFails++; $display("[TB] FAIL odd_idx[%0d]: got %0d want %0d", k, idxB, k); end
      if (k == 0) begin
        nChecks++; if (parB !== 1'b1) begin nFails++; $display("[TB] FAIL odd_parity_zero: got %b want 1", parB); end
      end
      if (k == 3) begin
        nChecks++; if (parB !== 1'b0) begin nFails++; $display("[TB] FAIL odd_parity_01: got %b want 0", parB); end
      end
      if (k == 7) begin
        nChecks++; if (parB !== 1'b1) begin nFails++; $display("[TB] FAIL odd_parity_03: got %b want 1", parB); end
      end
    end
    nChecks++; if (doneB !== 1'b1) begin nFails++; $display("[TB] FAIL odd_done: got %b want 1", doneB); end
    nChecks++; if (busyB !== 1'b0) begin nFails++; $display("[TB] FAIL odd_done_busy: got %b want 0", busyB); end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    iReset  = 1'b1;
    startA  = 1'b0;
    flagA   = 1'b0;
    startB  = 1'b0;
    flagB   = 1'b0;
    for (int i = 0; i < 4; i++) psiA[i] = '0;
    for (int i = 0; i < 48; i++) psiB[i] = '0;
    test_reset();
    test_full_transfer();
    test_overrun_restart();
    test_snapshot();
    test_priority();
    test_reset_mid_op();
    test_odd_parity_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Parametrised successor to the fixed 1-qubit output stage.
- Snapshots a final state-vector of NUM_WORDS words, each WORD_W bits, into an internal buffer on a start pulse.
- Presents the buffer one BYTE_W-bit byte at a time to the external microcontroller, advancing on each rising edge of its listener handshake line.
- Fully synchronous to i_clock, with configurable parity, a header byte, a done flag and clean restart.

Parameters:
- WORD_W, 16, bits per state-vector word; must be a multiple of BYTE_W.
- NUM_WORDS, 48, number of words in the state-vector.
- BYTE_W, 8, width of the output bus.
- PARITY_ODD, 0, 0 = even parity (parity = XOR of byte), 1 = odd parity (inverted XOR).
- HEADER, 8'h8B, byte driven after reset and after each start, before the first data byte.
- SYNC_STAGES, 2, flip-flop stages synchronising listener_flag; minimum 2.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- psi_f  in  [WORD_W-1:0] x NUM_WORDS  final state-vector; sampled only on an accepted start.
- start  in  1  one-cycle pulse requesting a new transfer.
- listener_flag  in  1  asynchronous handshake from the microcontroller; each rising edge requests the next byte.
- out  out  BYTE_W  current byte.
- parity  out  1  parity of out per PARITY_ODD.
- busy  out  1  high while in SEND.
- done  out  1  high in DONE until the next start or reset.
- byte_idx  out  clog2(TOTAL)  index of the last byte presented.

Behaviour:
- Derived constants: BPW = WORD_W/BYTE_W; TOTAL = NUM_WORDS*BPW.
- Byte order: word 0 first; within each word, most-significant byte first. Byte k = word k/BPW, slice BPW-1-(k%BPW).
- Reset (sampled on an i_clock edge): state = IDLE, out = HEADER, parity = parity(HEADER), busy = 0, done = 0, byte_idx = 0, sync chain cleared.
- Edge detect: listener_flag passes through SYNC_STAGES flops. A rising edge is detected when the last stage is 1 and its registered previous value is 0.
- Latency: out, parity and byte_idx update exactly SYNC_STAGES+1 i_clock cycles after the listener_flag rise.
- listener_flag must stay high and low for at least SYNC_STAGES+1 cycles; shorter pulses may be missed.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - Edges are ignored; out holds.
  - start: capture psi_f into the buffer, out = HEADER, parity = parity(HEADER), byte_idx = 0, go to SEND.
- SEND:
  - busy = 1; an internal counter cnt starts at 0.
  - Each detected edge: out = byte[cnt], parity = parity(byte[cnt]), byte_idx = cnt, cnt++.
  - The edge with cnt == TOTAL-1 presents the last byte and moves to DONE in the same cycle.
  - start is ignored in SEND.
  - psi_f changes have no effect, because the buffer is snapshotted.
- DONE:
  - done = 1, busy = 0; out and parity hold the last byte.
  - Further edges are ignored, with no wrap-around and no zero byte.
  - start: re-snapshot and go to SEND, identical to the IDLE path.
- Simultaneous start and detected edge in IDLE or DONE: start wins; the edge is discarded and out = HEADER.
- Reset mid-SEND: immediate return to reset values.
  - The buffer contents are don't-care.
  - A listener_flag held high through reset must not cause a spurious edge afterwards: the previous-value flop resets to 0 and the sync chain resets to 0, so a level still high after reset is detected only after the chain fills. This is accepted and documented; the host must drop listener_flag before the next start.
- Arithmetic: cnt is clog2(TOTAL+1) bits wide; no overflow is possible.
- Elaboration must fail via $error if WORD_W % BYTE_W != 0 or SYNC_STAGES < 2.

Decomposition:
- Package out_ser_pkg: state enum (IDLE/SEND/DONE), function calc_parity(byte, odd), localparam helper for TOTAL and byte-index width.
- One sub-module, edge_sync: a SYNC_STAGES synchroniser plus rising-edge detector with synchronous reset, producing a one-cycle rise pulse.
- Byte selection is a generic indexed part-select on the flattened buffer, not a case table.

Test Plan:
- Reset defaults: assert i_reset 3 cycles -> out = 8'h8B, parity = 0, busy = 0, done = 0, byte_idx = 0.
- Full transfer (WORD_W=16, NUM_WORDS=4, psi_f = {16'h1234, 16'hABCD, 16'h00FF, 16'h8001}): start, then 8 listener rises.
  - Bytes: 12, 34, AB, CD, 00, FF, 80, 01.
  - Even parity: 0, 1, 1, 1, 0, 0, 1, 1.
  - Each update arrives at SYNC_STAGES+1 cycles; done rises with the byte 01.
- Overrun and restart: 2 extra rises after done -> out stays 01. Then start with new psi_f -> out = 8'h8B and busy = 1; the first rise gives the new word 0 MSB.
- Parity and default depth: PARITY_ODD=1, default NUM_WORDS=48, psi_f[i] = i -> 96 bytes, alternating 00 and i. Parity of byte 00 = 1; parity of 8'h03 = 1; parity of 8'h01 = 0.
- Snapshot and priority:
  - Change psi_f mid-SEND -> the output stream is unchanged.
  - start and a detected edge in the same cycle in DONE -> out = 8'h8B and byte_idx = 0.
- Reset mid-operation: i_reset after byte 5 -> reset values. Then start and 1 rise -> byte 0 (12), not byte 6.
